// File: rtl/map_param_sched.sv
// map_param_sched: per-frame luma statistics and parameter scheduler.
// Measures mean luma and dark-pixel ratio over each active frame, then
// derives the local-contrast gain p_q (Q8.8) and the dark-blend weight
// p2_q (Q0.8) with an 8-step restoring divider during vertical blanking.
// Results are double-buffered and only take effect at a frame edge.
module map_param_sched #(
  parameter int QVAL    = 255,
  parameter int SHIFT   = 8,
  parameter int CNT_W   = 22,
  parameter int DARK_TH = 64,
  parameter int PQ_BASE = 256,
  parameter int PQ_GAIN = 256,
  parameter int PQ_MAX  = 1024,
  parameter int P2_GAIN = 256,
  parameter int P2Q_MAX = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [23:0] i_rgb,
  output logic [15:0] o_p_q,
  output logic [7:0]  o_p2_q,
  output logic [7:0]  o_mean,
  output logic        o_busy,
  output logic        o_upd,
  output logic        o_overrun
);

  localparam int SUM_W = CNT_W + 8;

  localparam logic [8:0]  DARK_TH_V = 9'(DARK_TH);
  localparam logic [31:0] QVAL_V    = 32'(QVAL);
  localparam logic [31:0] PQ_BASE_V = 32'(PQ_BASE);
  localparam logic [31:0] PQ_GAIN_V = 32'(PQ_GAIN);
  localparam logic [31:0] PQ_MAX_V  = 32'(PQ_MAX);
  localparam logic [31:0] P2_GAIN_V = 32'(P2_GAIN);
  localparam logic [31:0] P2Q_MAX_V = 32'(P2Q_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV_MEAN,
    S_DIV_DARK,
    S_CALC
  } state_t;

  state_t state_reg, state_next;

  // ---------------------------------------------------------------
  // Luma: weighted sum of B (bits 7:0), G (15:8), R (23:16)
  // ---------------------------------------------------------------
  logic [15:0] prod [3];
  logic [15:0] luma_full;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      localparam logic [15:0] COEF = (gi == 0) ? 16'd29 :
                                     (gi == 1) ? 16'd150 : 16'd77;
      assign prod[gi] = COEF * {8'd0, i_rgb[gi*8 +: 8]};
    end
  endgenerate

  assign luma_full = prod[0] + prod[1] + prod[2];

  logic [7:0] y_reg;
  logic       de_d1_reg;
  logic       vs_d1_reg, vs_d2_reg, vs_d3_reg;
  logic       frame_edge;
  logic       y_dark;

  // Luma register and vsync alignment delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg     <= '0;
      de_d1_reg <= 1'b0;
      vs_d1_reg <= 1'b0;
      vs_d2_reg <= 1'b0;
      vs_d3_reg <= 1'b0;
    end else begin
      y_reg     <= luma_full[15:8];
      de_d1_reg <= i_de;
      vs_d1_reg <= i_vs;
      vs_d2_reg <= vs_d1_reg;
      vs_d3_reg <= vs_d2_reg;
    end
  end

  // vs delayed two cycles so every pixel ahead of it has reached the accumulators
  assign frame_edge = vs_d2_reg & ~vs_d3_reg;
  assign y_dark     = ({1'b0, y_reg} < DARK_TH_V);

  // ---------------------------------------------------------------
  // Frame accumulators
  // ---------------------------------------------------------------
  logic [SUM_W-1:0] sum_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] dark_reg;

  // Accumulate qualified pixels; a frame edge restarts with the pixel present that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg  <= '0;
      cnt_reg  <= '0;
      dark_reg <= '0;
    end else if (frame_edge) begin
      sum_reg  <= de_d1_reg ? SUM_W'(y_reg) : '0;
      cnt_reg  <= CNT_W'(de_d1_reg);
      dark_reg <= CNT_W'(de_d1_reg & y_dark);
    end else if (de_d1_reg) begin
      sum_reg  <= sum_reg + SUM_W'(y_reg);
      cnt_reg  <= cnt_reg + CNT_W'(1);
      dark_reg <= dark_reg + CNT_W'(y_dark);
    end
  end

  // ---------------------------------------------------------------
  // Sequential divider and statistics snapshot
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] snap_cnt_reg;
  logic [CNT_W-1:0] snap_dark_reg;
  logic [SUM_W-1:0] div_rem_reg;   // holds the sum snapshot at the start of DIV_MEAN
  logic [SUM_W-1:0] div_den_reg;
  logic [6:0]       div_quo_reg;
  logic [2:0]       iter_reg;
  logic [7:0]       mean_calc_reg;
  logic [7:0]       ratio_reg;

  logic             div_ge;
  logic [SUM_W-1:0] div_diff;
  logic [7:0]       quo_next;
  logic             dark_full;
  logic             start;

  assign div_ge    = (div_rem_reg >= div_den_reg);
  assign div_diff  = div_rem_reg - div_den_reg;
  assign quo_next  = {div_quo_reg, div_ge};
  // All-dark frame: 256*cnt/cnt would overflow 8 bits, so saturate instead
  assign dark_full = (snap_dark_reg == snap_cnt_reg);
  assign start     = frame_edge && (state_reg == S_IDLE) && (cnt_reg != '0);

  // Next-state logic for the compute sequence
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (start) state_next = S_DIV_MEAN;
      S_DIV_MEAN: if (iter_reg == 3'd0) state_next = S_DIV_DARK;
      S_DIV_DARK: if (iter_reg == 3'd0) state_next = S_CALC;
      S_CALC:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Snapshot on an idle edge, then run restoring division MSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_cnt_reg  <= '0;
      snap_dark_reg <= '0;
      div_rem_reg   <= '0;
      div_den_reg   <= '0;
      div_quo_reg   <= '0;
      iter_reg      <= '0;
      mean_calc_reg <= '0;
      ratio_reg     <= '0;
    end else begin
      if (frame_edge && state_reg == S_IDLE) begin
        snap_cnt_reg  <= cnt_reg;
        snap_dark_reg <= dark_reg;
      end
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            div_rem_reg <= sum_reg;
            div_den_reg <= {1'b0, cnt_reg, 7'd0};
            div_quo_reg <= '0;
            iter_reg    <= 3'd7;
          end
        end
        S_DIV_MEAN: begin
          if (div_ge) div_rem_reg <= div_diff;
          div_quo_reg <= quo_next[6:0];
          div_den_reg <= div_den_reg >> 1;
          iter_reg    <= iter_reg - 3'd1;
          if (iter_reg == 3'd0) begin
            mean_calc_reg <= quo_next;
            div_rem_reg   <= {snap_dark_reg, 8'd0};
            div_den_reg   <= {1'b0, snap_cnt_reg, 7'd0};
            div_quo_reg   <= '0;
            iter_reg      <= 3'd7;
          end
        end
        S_DIV_DARK: begin
          if (!dark_full) begin
            if (div_ge) div_rem_reg <= div_diff;
            div_quo_reg <= quo_next[6:0];
            div_den_reg <= div_den_reg >> 1;
          end
          iter_reg <= iter_reg - 3'd1;
          if (iter_reg == 3'd0) ratio_reg <= dark_full ? 8'hFF : quo_next;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Parameter arithmetic
  // ---------------------------------------------------------------
  logic [31:0] pq_diff, pq_sum, p2_full;
  logic [15:0] pq_next;
  logic [7:0]  p2_next;

  // Gain and blend weight from the divider results, clamped
  always_comb begin
    pq_diff = QVAL_V - {24'd0, mean_calc_reg};
    pq_sum  = PQ_BASE_V + ((pq_diff * PQ_GAIN_V) >> SHIFT);
    p2_full = ({24'd0, ratio_reg} * P2_GAIN_V) >> SHIFT;
    pq_next = (pq_sum > PQ_MAX_V) ? PQ_MAX_V[15:0] : pq_sum[15:0];
    p2_next = (p2_full > P2Q_MAX_V) ? P2Q_MAX_V[7:0] : p2_full[7:0];
  end

  logic [15:0] shadow_pq_reg;
  logic [7:0]  shadow_p2_reg;
  logic        shadow_vld_reg;

  // Shadow/active double buffer; a CALC write in the edge cycle re-arms shadow_vld
  always_ff @(posedge clk) begin
    if (rst) begin
      o_p_q          <= PQ_BASE_V[15:0];
      o_p2_q         <= '0;
      o_mean         <= '0;
      o_upd          <= 1'b0;
      o_overrun      <= 1'b0;
      shadow_pq_reg  <= PQ_BASE_V[15:0];
      shadow_p2_reg  <= '0;
      shadow_vld_reg <= 1'b0;
    end else begin
      o_upd <= 1'b0;
      if (frame_edge && state_reg != S_IDLE) o_overrun <= 1'b1;
      if (frame_edge && shadow_vld_reg) begin
        o_p_q          <= shadow_pq_reg;
        o_p2_q         <= shadow_p2_reg;
        o_upd          <= 1'b1;
        shadow_vld_reg <= 1'b0;
      end
      if (state_reg == S_CALC) begin
        shadow_pq_reg  <= pq_next;
        shadow_p2_reg  <= p2_next;
        shadow_vld_reg <= 1'b1;
        o_mean         <= mean_calc_reg;
      end
    end
  end

  assign o_busy = (state_reg != S_IDLE);

endmodule

// File: tb/tb_map_param_sched.sv
// Testbench for map_param_sched: table of frames with a scoreboard that is
// popped on each o_upd pulse, plus hand sequences for overrun and reset.
module tb_map_param_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_vs;
  logic        i_de;
  logic [23:0] i_rgb;
  logic [15:0] o_p_q;
  logic [7:0]  o_p2_q;
  logic [7:0]  o_mean;
  logic        o_busy;
  logic        o_upd;
  logic        o_overrun;

  map_param_sched dut (
    .clk       (clk),
    .rst       (rst),
    .i_vs      (i_vs),
    .i_de      (i_de),
    .i_rgb     (i_rgb),
    .o_p_q     (o_p_q),
    .o_p2_q    (o_p2_q),
    .o_mean    (o_mean),
    .o_busy    (o_busy),
    .o_upd     (o_upd),
    .o_overrun (o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          na;
    logic [23:0] rgb_a;
    int          nb;
    logic [23:0] rgb_b;
    int          exp_pq;
    int          exp_p2;
    int          exp_mean;
  } vec_t;

  typedef struct {
    int pq;
    int p2;
    int mean;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pixels(input int n, input logic [23:0] rgb);
    for (int k = 0; k < n; k++) begin
      i_de  = 1'b1;
      i_rgb = rgb;
      tick(1);
    end
    i_de  = 1'b0;
    i_rgb = 24'd0;
  endtask

  // Raise vsync for two cycles; returns during cycle E+1
  task automatic vs_edge();
    i_vs = 1'b1;
    tick(2);
    i_vs = 1'b0;
    tick(1);
  endtask

  // Called at E+1; checks busy at E+1 and E+17, idle at E+18; returns at E+18
  task automatic busy_window(input int exp_busy, input string tag);
    chk({tag, "_busy_e1"}, int'(o_busy), exp_busy);
    tick(16);
    chk({tag, "_busy_e17"}, int'(o_busy), exp_busy);
    tick(1);
    chk({tag, "_busy_e18"}, int'(o_busy), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_p_q"},     int'(o_p_q), 256);
    chk({tag, "_p2_q"},    int'(o_p2_q), 0);
    chk({tag, "_mean"},    int'(o_mean), 0);
    chk({tag, "_busy"},    int'(o_busy), 0);
    chk({tag, "_upd"},     int'(o_upd), 0);
    chk({tag, "_overrun"}, int'(o_overrun), 0);
  endtask

  // Scoreboard: each o_upd pulse must match the oldest pending frame result
  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_upd) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL upd_unexpected: o_upd=1 with p_q=%0d p2_q=%0d, expected no update",
                 o_p_q, o_p2_q);
      end else begin
        e = sb_q.pop_front();
        chk("upd_p_q", int'(o_p_q), e.pq);
        chk("upd_p2_q", int'(o_p2_q), e.p2);
        chk("upd_mean", int'(o_mean), e.mean);
        $display("upd: p_q=%0d p2_q=%0d mean=%0d (expected %0d %0d %0d)",
                 o_p_q, o_p2_q, o_mean, e.pq, e.p2, e.mean);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs [8];

  initial begin
    // {pixels A, rgb A, pixels B, rgb B, p_q, p2_q, mean}
    vecs[0] = '{16, 24'h808080, 0,  24'h000000, 383, 0,   128};
    vecs[1] = '{16, 24'h000000, 0,  24'h000000, 511, 128, 0};
    vecs[2] = '{8,  24'h000000, 8,  24'hFFFFFF, 384, 128, 127};
    vecs[3] = '{16, 24'hFFFFFF, 0,  24'h000000, 256, 0,   255};
    vecs[4] = '{16, 24'h404040, 0,  24'h000000, 447, 0,   64};
    vecs[5] = '{16, 24'h3F3F3F, 0,  24'h000000, 448, 128, 63};
    vecs[6] = '{4,  24'h000000, 12, 24'h00FF00, 400, 64,  111};
    vecs[7] = '{5,  24'h646464, 2,  24'h0000FF, 432, 73,  79};

    rst   = 1'b1;
    i_vs  = 1'b0;
    i_de  = 1'b0;
    i_rgb = 24'd0;
    tick(3);
    chk_reset_vals("reset");
    rst = 1'b0;
    tick(2);

    // Table: result of frame i appears at the edge closing frame i+1
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      drive_pixels(vecs[i].na, vecs[i].rgb_a);
      drive_pixels(vecs[i].nb, vecs[i].rgb_b);
      e.pq = vecs[i].exp_pq;
      e.p2 = vecs[i].exp_p2;
      e.mean = vecs[i].exp_mean;
      sb_q.push_back(e);
      $display("frame %0d driven: expect p_q=%0d p2_q=%0d mean=%0d", i, e.pq, e.p2, e.mean);
      tick(2);
      vs_edge();
      busy_window(1, "tbl");
      tick(2);
    end

    // Empty frame: loads last result, no computation
    vs_edge();
    busy_window(0, "empty1");
    tick(2);

    // Another empty edge: nothing pending, parameters held
    vs_edge();
    chk("noframe_upd", int'(o_upd), 0);
    chk("noframe_p_q", int'(o_p_q), 432);
    chk("noframe_p2_q", int'(o_p2_q), 73);
    busy_window(0, "empty2");
    tick(2);

    // Overrun: second edge 10 cycles after the first
    drive_pixels(16, 24'h808080);
    begin
      exp_t e;
      e.pq = 383; e.p2 = 0; e.mean = 128;
      sb_q.push_back(e);
    end
    tick(2);
    vs_edge();                     // E1+1
    chk("ovr_before", int'(o_overrun), 0);
    tick(7);                       // E1+8
    vs_edge();                     // E2+1 = E1+11
    chk("ovr_set", int'(o_overrun), 1);
    tick(6);                       // E1+17
    chk("ovr_busy_e17", int'(o_busy), 1);
    tick(1);                       // E1+18
    chk("ovr_busy_e18", int'(o_busy), 0);
    chk("ovr_mean", int'(o_mean), 128);
    tick(5);
    vs_edge();
    busy_window(0, "ovr_load");
    chk("ovr_sticky", int'(o_overrun), 1);
    $display("overrun sequence done: overrun=%0d", o_overrun);
    tick(2);

    // Reset during DIV_MEAN
    drive_pixels(16, 24'h000000);
    tick(2);
    vs_edge();                     // E+1
    tick(4);                       // E+5
    chk("rst_busy_before", int'(o_busy), 1);
    rst = 1'b1;
    tick(1);                       // E+6
    chk_reset_vals("midrst");
    $display("mid-computation reset applied: p_q=%0d busy=%0d", o_p_q, o_busy);
    rst = 1'b0;
    tick(2);

    // Normal frame after the reset
    drive_pixels(8, 24'h000000);
    drive_pixels(8, 24'hFFFFFF);
    begin
      exp_t e;
      e.pq = 384; e.p2 = 128; e.mean = 127;
      sb_q.push_back(e);
    end
    tick(2);
    vs_edge();
    chk("post_rst_first_upd", int'(o_upd), 0);
    busy_window(1, "post_rst");
    tick(2);
    vs_edge();
    busy_window(0, "post_rst_load");
    tick(2);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
